// File: rtl/h_pfn_pkg.sv
// Shared definitions for the host PFN path: page geometry, PFN type and
// default filter size. The PFN buffer imports the same package.
package h_pfn_pkg;

  localparam int PAGE_SHIFT_DEF   = 12;
  localparam int PFN_WIDTH_DEF    = 32;
  localparam int FILTER_DEPTH_DEF = 8;

  typedef logic [PFN_WIDTH_DEF-1:0] pfn_t;

endpackage : h_pfn_pkg

// File: rtl/h_pfn_filter.sv
// Recently-seen PFN filter: small fully-associative CAM with FIFO
// replacement. Lookup is combinational on current contents; insert and
// flush take effect on the next edge, flush winning over insert.
module h_pfn_filter
  import h_pfn_pkg::*;
#(
  parameter int PFN_WIDTH    = PFN_WIDTH_DEF,
  parameter int FILTER_DEPTH = FILTER_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [PFN_WIDTH-1:0]          lookup_pfn,
  input  logic                          insert,
  input  logic [PFN_WIDTH-1:0]          insert_pfn,
  input  logic                          flush,
  output logic                          hit,
  output logic [$clog2(FILTER_DEPTH):0] occ
);

  localparam int PTR_W = $clog2(FILTER_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [PFN_WIDTH-1:0]    entry [FILTER_DEPTH];
  logic [FILTER_DEPTH-1:0] valid;
  logic [PTR_W-1:0]        ptr;

  // Match lookup PFN against every valid entry
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < FILTER_DEPTH; i++) begin
      if (valid[i] && (entry[i] == lookup_pfn)) hit = 1'b1;
    end
  end

  // Valid bits, FIFO pointer and saturating occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= '0;
      ptr   <= '0;
      occ   <= '0;
    end else if (flush) begin
      valid <= '0;
      ptr   <= '0;
      occ   <= '0;
    end else if (insert) begin
      valid[ptr] <= 1'b1;
      ptr        <= ptr + PTR_W'(1);
      if (occ != OCC_W'(FILTER_DEPTH)) occ <= occ + OCC_W'(1);
    end
  end

  // Entry storage; contents are meaningless until the valid bit is set
  always_ff @(posedge clk) begin
    if (insert) entry[ptr] <= insert_pfn;
  end

endmodule : h_pfn_filter

// File: rtl/h_pfn_tracker.sv
// Host PFN tracker: samples request addresses, converts to PFNs, filters
// recent repeats and emits one write per new PFN. Keeps saturating
// duplicate / out-of-range / overflow-drop counters for the CSR block.
module h_pfn_tracker
  import h_pfn_pkg::*;
#(
  parameter int ADDR_WIDTH   = 64,
  parameter int PAGE_SHIFT   = PAGE_SHIFT_DEF,
  parameter int PFN_WIDTH    = PFN_WIDTH_DEF,
  parameter int FILTER_DEPTH = FILTER_DEPTH_DEF,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          req_valid,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic                          req_is_write,
  input  logic                          track_en,
  input  logic                          track_wr_only,
  input  logic                          filter_flush,
  input  logic                          wr_idx_rst,
  input  logic                          wr_overflow,
  output logic                          pfn_wr_en,
  output logic [PFN_WIDTH-1:0]          pfn_addr_o,
  output logic [CNT_WIDTH-1:0]          dup_cnt,
  output logic [CNT_WIDTH-1:0]          oob_cnt,
  output logic [CNT_WIDTH-1:0]          drop_cnt,
  output logic [$clog2(FILTER_DEPTH):0] filter_occ
);

  localparam int PFN_TOP = PAGE_SHIFT + PFN_WIDTH;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  logic                 accept;
  logic                 oob_req;
  logic                 vld_p0, vld_p1;
  logic                 oob_p0, oob_p1;
  logic [PFN_WIDTH-1:0] pfn_p0, pfn_p1;
  logic [PFN_WIDTH-1:0] pfn_hold;
  logic                 hit, emit, insert, flush;
  logic                 unused_page_offset;

  assign accept             = req_valid & track_en & (~track_wr_only | req_is_write);
  assign oob_req            = |(req_addr >> PFN_TOP);
  assign unused_page_offset = ^req_addr[PAGE_SHIFT-1:0];

  // S0: capture accepted request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= accept;
      vld_p1 <= vld_p0;
    end
  end

  // S0/S1 data, qualified by vld_p0/vld_p1
  always_ff @(posedge clk) begin
    pfn_p0 <= req_addr[PFN_TOP-1:PAGE_SHIFT];
    oob_p0 <= oob_req;
    pfn_p1 <= pfn_p0;
    oob_p1 <= oob_p0;
  end

  // S1: decide emit, lookup and insert happen in the same cycle
  assign emit      = vld_p1 & ~oob_p1 & ~hit;
  assign insert    = emit & ~wr_overflow;
  assign flush     = filter_flush | wr_idx_rst;
  assign pfn_wr_en = emit;
  assign pfn_addr_o = emit ? pfn_p1 : pfn_hold;

  h_pfn_filter #(
    .PFN_WIDTH    (PFN_WIDTH),
    .FILTER_DEPTH (FILTER_DEPTH)
  ) u_filter (
    .clk        (clk),
    .reset_n    (reset_n),
    .lookup_pfn (pfn_p1),
    .insert     (insert),
    .insert_pfn (pfn_p1),
    .flush      (flush),
    .hit        (hit),
    .occ        (filter_occ)
  );

  // Last emitted PFN so the buffer address stays stable between writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  pfn_hold <= '0;
    else if (emit) pfn_hold <= pfn_p1;
  end

  // Statistics counters, saturating, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dup_cnt  <= '0;
      oob_cnt  <= '0;
      drop_cnt <= '0;
    end else if (vld_p1) begin
      if (oob_p1)           oob_cnt  <= sat_inc(oob_cnt);
      else if (hit)         dup_cnt  <= sat_inc(dup_cnt);
      else if (wr_overflow) drop_cnt <= sat_inc(drop_cnt);
    end
  end

endmodule : h_pfn_tracker
